mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage_pkg.sv | 17 +
 rtl/mem_stage_if.sv | 28 ++
 rtl/mem_stage_data_ram.sv | 17 +
 rtl/mem_stage.sv | 59 +++++
 tb/tb_mem_stage.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared widths, IO map and pipeline register types for the memory stage
package mem_stage_pkg;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 8;
  localparam logic [ADDR_W-1:0] IO_OUT_ADDR = 8'hFF;
  localparam logic [ADDR_W-1:0] IO_IN_ADDR = 8'hFE;
  typedef struct packed {
    logic mwe;
    logic mux;
    logic rwe;
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] data_b;
    logic [7:0] c_reg;
  } exmem_t;
  localparam exmem_t BUBBLE = '0;
  typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_IO} wb_sel_e;
endpackage

// File: rtl/mem_stage_if.sv
// mem_stage_if: EX-side inputs plus forwarding, writeback and IO outputs of the memory stage
import mem_stage_pkg::*;
interface mem_stage_if;
  logic stall;
  logic flush;
  logic MWE;
  logic Mux;
  logic RWE;
  logic [DATA_W-1:0] ALU_Result;
  logic [DATA_W-1:0] Data_B;
  logic [7:0] C_Reg;
  logic [DATA_W-1:0] IO_In;
  logic [DATA_W-1:0] Fwd_Data;
  logic [7:0] Fwd_Reg;
  logic Fwd_RWE;
  logic [DATA_W-1:0] WB_Data;
  logic [7:0] WB_Reg;
  logic WB_RWE;
  logic [DATA_W-1:0] IO_Out;
  modport master (
    output stall, flush, MWE, Mux, RWE, ALU_Result, Data_B, C_Reg, IO_In,
    input Fwd_Data, Fwd_Reg, Fwd_RWE, WB_Data, WB_Reg, WB_RWE, IO_Out
  );
  modport slave (
    input stall, flush, MWE, Mux, RWE, ALU_Result, Data_B, C_Reg, IO_In,
    output Fwd_Data, Fwd_Reg, Fwd_RWE, WB_Data, WB_Reg, WB_RWE, IO_Out
  );
endinterface

// File: rtl/mem_stage_data_ram.sv
// data_ram: single-port synchronous RAM, read-first, registered read, contents never reset
module data_ram #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [2**ADDR_W];
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end
endmodule

// File: rtl/mem_stage.sv
// mem_stage: EX/MEM and MEM/WB pipeline registers, data memory access, IO mapping and writeback mux
import mem_stage_pkg::*;
module mem_stage #(
  parameter int DATA_W = mem_stage_pkg::DATA_W,
  parameter int ADDR_W = mem_stage_pkg::ADDR_W,
  parameter logic [ADDR_W-1:0] IO_OUT_ADDR = mem_stage_pkg::IO_OUT_ADDR,
  parameter logic [ADDR_W-1:0] IO_IN_ADDR = mem_stage_pkg::IO_IN_ADDR
) (
  input logic       clk,
  input logic       rst,
  mem_stage_if.slave bus
);
  exmem_t ex_d, ex_q;
  wb_sel_e wb_sel;
  logic [DATA_W-1:0] wb_alu, io_q, rd, io_out;
  logic [7:0] wb_reg;
  logic wb_rwe;
  logic [ADDR_W-1:0] addr;
  logic is_io_out, is_io_in;
  assign ex_d = (bus.stall || bus.flush) ? BUBBLE
              : {bus.MWE, bus.Mux, bus.RWE, bus.ALU_Result, bus.Data_B, bus.C_Reg};
  assign addr = ex_q.alu[ADDR_W-1:0];
  assign is_io_out = addr == IO_OUT_ADDR;
  assign is_io_in = addr == IO_IN_ADDR;
  // the RAM read register doubles as the MEM/WB copy of the loaded word
  data_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
    .clk(clk),
    .we(ex_q.mwe && !is_io_out),
    .addr(addr),
    .wdata(ex_q.data_b),
    .rdata(rd)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q <= BUBBLE;
      wb_sel <= WB_ALU;
      wb_alu <= '0;
      io_q <= '0;
      wb_reg <= '0;
      wb_rwe <= 1'b0;
      io_out <= '0;
    end else begin
      ex_q <= ex_d;
      wb_sel <= !ex_q.mux ? WB_ALU : is_io_in ? WB_IO : WB_MEM;
      wb_alu <= ex_q.alu;
      io_q <= bus.IO_In;
      wb_reg <= ex_q.c_reg;
      wb_rwe <= ex_q.rwe;
      if (ex_q.mwe && is_io_out) io_out <= ex_q.data_b;
    end
  end
  assign bus.Fwd_Data = ex_q.alu;
  assign bus.Fwd_Reg = ex_q.c_reg;
  assign bus.Fwd_RWE = ex_q.rwe;
  assign bus.WB_Data = wb_sel == WB_MEM ? rd : wb_sel == WB_IO ? io_q : wb_alu;
  assign bus.WB_Reg = wb_reg;
  assign bus.WB_RWE = wb_rwe;
  assign bus.IO_Out = io_out;
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed and random stimulus checked against an instruction-level model of the memory stage
module tb_mem_stage;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  mem_stage_if bus();
  mem_stage dut (.clk(clk), .rst(rst), .bus(bus));
  typedef struct packed {
    logic mwe;
    logic mux;
    logic rwe;
    logic [15:0] alu;
    logic [15:0] db;
    logic [7:0] cr;
  } ins_t;
  ins_t m_ex;
  logic [15:0] mem_m [256];
  bit known [256];
  logic [15:0] m_wbd, m_io;
  logic [7:0] m_wbr;
  logic m_wbrwe;
  bit m_wbk;
  int n_chk = 0;
  int n_err = 0;
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  function automatic void model_reset();
    m_ex = '0;
    m_wbd = '0;
    m_wbr = '0;
    m_wbrwe = 1'b0;
    m_wbk = 1'b1;
    m_io = '0;
  endfunction
  // the instruction in MEM completes (result and store) and the EX instruction enters MEM
  function automatic void model_edge();
    logic [7:0] a;
    a = m_ex.alu[7:0];
    m_wbk = 1'b1;
    m_wbd = m_ex.alu;
    if (m_ex.mux) begin
      if (a == 8'hFE) m_wbd = bus.IO_In;
      else begin
        m_wbd = mem_m[a];
        m_wbk = known[a];
      end
    end
    m_wbr = m_ex.cr;
    m_wbrwe = m_ex.rwe;
    if (m_ex.mwe) begin
      if (a == 8'hFF) m_io = m_ex.db;
      else begin
        mem_m[a] = m_ex.db;
        known[a] = 1'b1;
      end
    end
    m_ex = (bus.stall || bus.flush) ? '0 : {bus.MWE, bus.Mux, bus.RWE, bus.ALU_Result, bus.Data_B, bus.C_Reg};
  endfunction
  task automatic check_all();
    chk("fwd_data", bus.Fwd_Data, m_ex.alu);
    chk("fwd_reg", 16'(bus.Fwd_Reg), 16'(m_ex.cr));
    chk("fwd_rwe", 16'(bus.Fwd_RWE), 16'(m_ex.rwe));
    if (m_wbk) chk("wb_data", bus.WB_Data, m_wbd);
    chk("wb_reg", 16'(bus.WB_Reg), 16'(m_wbr));
    chk("wb_rwe", 16'(bus.WB_RWE), 16'(m_wbrwe));
    chk("io_out", bus.IO_Out, m_io);
  endtask
  task automatic cyc(input logic mwe, input logic mux, input logic rwe, input logic [15:0] alu,
                     input logic [15:0] db, input logic [7:0] cr, input logic stl = 1'b0, input logic fl = 1'b0);
    bus.MWE = mwe;
    bus.Mux = mux;
    bus.RWE = rwe;
    bus.ALU_Result = alu;
    bus.Data_B = db;
    bus.C_Reg = cr;
    bus.stall = stl;
    bus.flush = fl;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask
  task automatic nop();
    cyc(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 8'h0);
  endtask
  initial begin
    int wr7;
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    bus.MWE = 1'b0;
    bus.Mux = 1'b0;
    bus.RWE = 1'b0;
    bus.ALU_Result = '0;
    bus.Data_B = '0;
    bus.C_Reg = '0;
    bus.IO_In = '0;
    model_reset();
    #1 rst = 1'b1;
    #1 check_all();
    @(negedge clk);
    check_all();
    rst = 1'b0;
    for (int a = 0; a < 255; a++) cyc(1'b1, 1'b0, 1'b0, 16'(a), 16'($urandom), 8'h0);
    // store then load of the same word
    cyc(1'b1, 1'b0, 1'b0, 16'h0010, 16'hBEEF, 8'h0);
    cyc(1'b0, 1'b1, 1'b1, 16'h0010, 16'h0, 8'd3);
    nop();
    chk("load_beef_data", bus.WB_Data, 16'hBEEF);
    chk("load_beef_reg", 16'(bus.WB_Reg), 16'd3);
    chk("load_beef_rwe", 16'(bus.WB_RWE), 16'd1);
    // ALU result forwarding then writeback
    cyc(1'b0, 1'b0, 1'b1, 16'h1234, 16'h0, 8'd5);
    chk("fwd_1234", bus.Fwd_Data, 16'h1234);
    nop();
    chk("wb_1234", bus.WB_Data, 16'h1234);
    chk("wb_reg5", 16'(bus.WB_Reg), 16'd5);
    // three stall bubbles, then exactly one writeback of the held instruction
    wr7 = 0;
    for (int k = 0; k < 3; k++) begin
      cyc(1'b0, 1'b0, 1'b1, 16'h55AA, 16'h0, 8'd7, 1'b1);
      chk("stall_bubble", 16'(bus.Fwd_RWE), 16'd0);
      if (bus.WB_RWE && bus.WB_Reg == 8'd7) wr7++;
    end
    for (int k = 0; k < 3; k++) begin
      if (k == 0) cyc(1'b0, 1'b0, 1'b1, 16'h55AA, 16'h0, 8'd7);
      else nop();
      if (bus.WB_RWE && bus.WB_Reg == 8'd7) wr7++;
    end
    chk("stall_once", 16'(wr7), 16'd1);
    // memory-mapped IO
    bus.IO_In = 16'h7777;
    cyc(1'b1, 1'b0, 1'b0, 16'h00FF, 16'h00A5, 8'h0);
    nop();
    chk("io_out_a5", bus.IO_Out, 16'h00A5);
    cyc(1'b0, 1'b1, 1'b1, 16'h00FE, 16'h0, 8'd9);
    nop();
    chk("io_in_7777", bus.WB_Data, 16'h7777);
    // flushed store is dropped, wrapped address hits the same word
    cyc(1'b1, 1'b0, 1'b0, 16'h0020, 16'h1111, 8'h0);
    cyc(1'b1, 1'b0, 1'b0, 16'h0020, 16'h2222, 8'h0, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 1'b1, 16'h0020, 16'h0, 8'd4);
    nop();
    chk("flush_kept", bus.WB_Data, 16'h1111);
    cyc(1'b1, 1'b0, 1'b0, 16'h0120, 16'h3333, 8'h0);
    cyc(1'b0, 1'b1, 1'b1, 16'h0020, 16'h0, 8'd4);
    nop();
    chk("wrap_store", bus.WB_Data, 16'h3333);
    // asynchronous reset with a store in EX/MEM
    cyc(1'b0, 1'b0, 1'b1, 16'h0ABC, 16'h0, 8'd6);
    cyc(1'b1, 1'b0, 1'b1, 16'h0030, 16'h4444, 8'd2);
    #2 rst = 1'b1;
    #1 chk("rst_fwd_data", bus.Fwd_Data, 16'h0);
    chk("rst_fwd_rwe", 16'(bus.Fwd_RWE), 16'd0);
    chk("rst_wb_data", bus.WB_Data, 16'h0);
    chk("rst_wb_rwe", 16'(bus.WB_RWE), 16'd0);
    chk("rst_io_out", bus.IO_Out, 16'h0);
    model_reset();
    check_all();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_all();
    cyc(1'b0, 1'b1, 1'b1, 16'h0030, 16'h0, 8'd1);
    nop();
    for (int i = 0; i < 400; i++) begin
      logic [2:0] r;
      logic [15:0] ad;
      r = 3'($urandom_range(0, 7));
      ad = {8'($urandom), r == 3'd0 ? 8'hFE : r == 3'd1 ? 8'hFF : 8'($urandom_range(0, 15))};
      bus.IO_In = 16'($urandom);
      cyc(1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ad,
          16'($urandom), 8'($urandom), 1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 9) == 0));
    end
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
